asteroid_spawn_scheduler: RTL and testbench

Sequences the three asteroid_move slots. Each frame it decides when a new asteroid enters, which free slot it uses, and which entry lane it takes. Tracks slot occupancy from spawn to off-screen exit. Ramps difficulty by shortening the inter-spawn gap as play time accumulates. Sits between rng/collide logic and the asteroid_move instances in top, replacing the free-running type[] enables.

---
 rtl/game_pkg.sv | 31 +++
 rtl/slot_picker.sv | 30 +++
 rtl/asteroid_spawn_scheduler.sv | 137 +++++++++++++
 tb/tb_asteroid_spawn_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the asteroid spawn scheduler.
//   state_e   : scheduler FSM states
//   NUM_LANES : number of asteroid entry lanes
//   LANE_W    : width of the lane index
//   LVL_W     : width of the difficulty level
//   gap()     : inter-spawn gap, in frames, for a given level
package game_pkg;

  typedef enum logic [0:0] {
    COOLDOWN = 1'b0,
    PICK     = 1'b1
  } state_e;

  localparam int NUM_LANES = 8;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int LVL_W     = 3;

  // The comparison is done before any subtraction of the level term, so the
  // result can never wrap below MIN_GAP.
  function automatic int gap(input int lvl, input int base_gap,
                             input int gap_step, input int min_gap);
    int result;
    if (lvl * gap_step >= base_gap - min_gap) begin
      result = min_gap;
    end else begin
      result = base_gap - lvl * gap_step;
    end
    return result;
  endfunction

endpackage

// File: rtl/slot_picker.sv
// Combinational rotating-priority first-free finder.
//   busy_i  : occupancy mask, one bit per slot
//   start_i : slot index where the scan begins (must be < NUM_SLOTS)
//   found_o : at least one slot is free
//   grant_o : one-hot mask of the first free slot at or above start_i, wrapping
module slot_picker #(
  parameter int NUM_SLOTS = 3
) (
  input  logic [NUM_SLOTS-1:0] busy_i,
  input  logic [1:0]           start_i,
  output logic                 found_o,
  output logic [NUM_SLOTS-1:0] grant_o
);

  logic [NUM_SLOTS-1:0]   free_rot;
  logic [NUM_SLOTS-1:0]   low_rot;
  logic [2*NUM_SLOTS-1:0] grant_wide;

  // Rotate so that bit 0 is the start slot; the doubled vector gives the wrap.
  assign free_rot = ~NUM_SLOTS'({busy_i, busy_i} >> start_i);

  // Isolate the lowest set bit, i.e. the first free slot in scan order.
  assign low_rot = free_rot & (~free_rot + NUM_SLOTS'(1));

  // Rotate the grant back into slot numbering.
  assign grant_wide = {{NUM_SLOTS{1'b0}}, low_rot} << start_i;
  assign grant_o    = grant_wide[NUM_SLOTS-1:0] | grant_wide[2*NUM_SLOTS-1:NUM_SLOTS];
  assign found_o    = |free_rot;

endmodule

// File: rtl/asteroid_spawn_scheduler.sv
// Decides when a new asteroid enters, which free slot it takes and which lane
// it enters on; tracks slot occupancy and ramps difficulty with play time.
//   clk         : pixel clock
//   reset       : synchronous active-high reset, overrides everything
//   frame_tick  : one-cycle pulse per frame
//   halt        : collision freeze; scheduling and level stop, slot_done still honoured
//   random      : rng; [1:0] start slot, [4:2] lane
//   slot_done   : per-slot pulse when that asteroid leaves the screen
//   spawn       : one-hot launch pulse
//   slot_active : slot occupancy
//   spawn_lane  : lane of the current launch, held between launches
//   level       : current difficulty level
module asteroid_spawn_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS    = 3,
  parameter int BASE_GAP     = 90,
  parameter int GAP_STEP     = 10,
  parameter int MIN_GAP      = 20,
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 halt,
  input  logic [4:0]           random,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] spawn,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [LANE_W-1:0]    spawn_lane,
  output logic [LVL_W-1:0]     level
);

  localparam int CNT_MAX = (BASE_GAP > LEVEL_FRAMES) ? BASE_GAP : LEVEL_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]     lvl_cnt_q, lvl_cnt_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [NUM_SLOTS-1:0] spawn_q, spawn_d;
  logic [LANE_W-1:0]    lane_q, lane_d;

  logic                 tick_en;
  logic [1:0]           start;
  logic                 found;
  logic [NUM_SLOTS-1:0] grant;
  logic [CNT_W-1:0]     reload_gap;

  assign tick_en    = frame_tick & ~halt;
  assign start      = 2'(int'(random[1:0]) % NUM_SLOTS);
  // Uses the registered level, so a level step in the reload cycle is not seen.
  assign reload_gap = CNT_W'(gap(int'(level_q), BASE_GAP, GAP_STEP, MIN_GAP));

  slot_picker #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_picker (
    .busy_i  (active_q),
    .start_i (start),
    .found_o (found),
    .grant_o (grant)
  );

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    lvl_cnt_d = lvl_cnt_q;
    level_d   = level_q;
    lane_d    = lane_q;
    spawn_d   = '0;
    // A slot freed this cycle is only visible to the picker next cycle, so
    // the clear and a grant can never target the same slot.
    active_d  = active_q & ~slot_done;

    if (tick_en) begin
      if (lvl_cnt_q == CNT_W'(LEVEL_FRAMES - 1)) begin
        lvl_cnt_d = '0;
        if (level_q != LVL_W'(MAX_LEVEL)) begin
          level_d = level_q + LVL_W'(1);
        end
      end else begin
        lvl_cnt_d = lvl_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      COOLDOWN: begin
        if (tick_en) begin
          if (gap_cnt_q == CNT_W'(1)) begin
            state_d = PICK;
          end else begin
            gap_cnt_d = gap_cnt_q - CNT_W'(1);
          end
        end
      end
      PICK: begin
        // With no free slot we stay here and rescan every cycle.
        if (!halt && found) begin
          spawn_d   = grant;
          active_d  = active_d | grant;
          lane_d    = random[4:2];
          state_d   = COOLDOWN;
          gap_cnt_d = reload_gap;
        end
      end
      default: state_d = COOLDOWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COOLDOWN;
      gap_cnt_q <= CNT_W'(BASE_GAP);
      lvl_cnt_q <= '0;
      level_q   <= '0;
      active_q  <= '0;
      spawn_q   <= '0;
      lane_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      lvl_cnt_q <= lvl_cnt_d;
      level_q   <= level_d;
      active_q  <= active_d;
      spawn_q   <= spawn_d;
      lane_q    <= lane_d;
    end
  end

  assign spawn       = spawn_q;
  assign slot_active = active_q;
  assign spawn_lane  = lane_q;
  assign level       = level_q;

endmodule

// File: tb/tb_asteroid_spawn_scheduler.sv
module tb_asteroid_spawn_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       halt = 1'b0;
  logic [4:0] random = 5'b10110;
  logic [2:0] slot_done = 3'b000;
  logic [2:0] spawn;
  logic [2:0] slot_active;
  logic [2:0] spawn_lane;
  logic [2:0] level;

  logic [2:0] pk_busy = 3'b000;
  logic [1:0] pk_start = 2'd0;
  logic       pk_found;
  logic [2:0] pk_grant;

  int checks = 0;
  int errors = 0;
  int spawn_cnt = 0;

  always #5 clk = ~clk;

  asteroid_spawn_scheduler #(
    .NUM_SLOTS(3), .BASE_GAP(90), .GAP_STEP(10), .MIN_GAP(20),
    .LEVEL_FRAMES(600), .MAX_LEVEL(7)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .halt(halt),
    .random(random), .slot_done(slot_done), .spawn(spawn),
    .slot_active(slot_active), .spawn_lane(spawn_lane), .level(level)
  );

  slot_picker #(.NUM_SLOTS(3)) u_pk (
    .busy_i(pk_busy), .start_i(pk_start), .found_o(pk_found), .grant_o(pk_grant)
  );

  typedef struct {
    logic [4:0] rnd;
    logic [2:0] exp_spawn;
    logic [2:0] exp_lane;
  } top_vec_t;

  typedef struct {
    logic [2:0] busy;
    logic [1:0] start;
    logic       found;
    logic [2:0] grant;
  } pk_vec_t;

  top_vec_t tv[4];
  pk_vec_t  pv[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (spawn != 3'b000) spawn_cnt++;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    halt = 1'b0;
    slot_done = 3'b000;
    step();
    reset = 1'b0;
    spawn_cnt = 0;
  endtask

  function automatic int lvl_model(input int n);
    return (n / 600 > 7) ? 7 : n / 600;
  endfunction

  function automatic int gap_model(input int l);
    return (l * 10 >= 90 - 20) ? 20 : 90 - l * 10;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_tick;
    int exp_gap;
    int got;

    tv[0] = '{5'b10110, 3'b100, 3'd5};
    tv[1] = '{5'b00011, 3'b001, 3'd0};
    tv[2] = '{5'b11101, 3'b010, 3'd7};
    tv[3] = '{5'b01000, 3'b001, 3'd2};

    pv[0] = '{3'b000, 2'd0, 1'b1, 3'b001};
    pv[1] = '{3'b000, 2'd2, 1'b1, 3'b100};
    pv[2] = '{3'b001, 2'd0, 1'b1, 3'b010};
    pv[3] = '{3'b011, 2'd1, 1'b1, 3'b100};
    pv[4] = '{3'b110, 2'd2, 1'b1, 3'b001};
    pv[5] = '{3'b101, 2'd2, 1'b1, 3'b010};
    pv[6] = '{3'b111, 2'd1, 1'b0, 3'b000};
    pv[7] = '{3'b100, 2'd1, 1'b1, 3'b010};
    pv[8] = '{3'b010, 2'd1, 1'b1, 3'b100};
    pv[9] = '{3'b011, 2'd2, 1'b1, 3'b100};

    // Reset state
    step();
    check("rst_spawn", 32'(spawn), 0);
    check("rst_active", 32'(slot_active), 0);
    check("rst_lane", 32'(spawn_lane), 0);
    check("rst_level", 32'(level), 0);
    reset = 1'b0;

    // Picker table
    for (int i = 0; i < 10; i++) begin
      pk_busy = pv[i].busy;
      pk_start = pv[i].start;
      #1;
      check("pick_found", 32'(pk_found), 32'(pv[i].found));
      check("pick_grant", 32'(pk_grant), 32'(pv[i].grant));
    end

    // First spawn from reset for several random values
    for (int i = 0; i < 4; i++) begin
      random = tv[i].rnd;
      do_reset();
      ticks(90);
      check("first_early", spawn_cnt, 0);
      step();
      check("first_spawn", 32'(spawn), 32'(tv[i].exp_spawn));
      check("first_active", 32'(slot_active), 32'(tv[i].exp_spawn));
      check("first_lane", 32'(spawn_lane), 32'(tv[i].exp_lane));
    end

    // Fill all slots, wait while full, free slot 1
    random = 5'b10110;
    do_reset();
    ticks(90); step();
    check("fill1", 32'(spawn), 32'(3'b100));
    ticks(90); step();
    check("fill2", 32'(spawn), 32'(3'b001));
    check("fill2_act", 32'(slot_active), 32'(3'b101));
    ticks(90); step();
    check("fill3", 32'(spawn), 32'(3'b010));
    check("fill3_act", 32'(slot_active), 32'(3'b111));
    ticks(90);
    spawn_cnt = 0;
    ticks(50);
    check("full_nospawn", spawn_cnt, 0);
    check("full_act", 32'(slot_active), 32'(3'b111));
    slot_done = 3'b010;
    step();
    slot_done = 3'b000;
    check("done_act", 32'(slot_active), 32'(3'b101));
    check("done_spawn0", 32'(spawn), 0);
    step();
    check("refill_spawn", 32'(spawn), 32'(3'b010));
    check("refill_act", 32'(slot_active), 32'(3'b111));
    check("refill_lane", 32'(spawn_lane), 5);
    step();
    check("spawn_pulse", 32'(spawn), 0);

    // Wrap scan: start index 3 mod 3 = 0 with slot 0 busy
    random = 5'b11111;
    do_reset();
    ticks(90); step();
    check("wrap_first", 32'(spawn), 32'(3'b001));
    ticks(90); step();
    check("wrap_spawn", 32'(spawn), 32'(3'b010));
    check("wrap_act", 32'(slot_active), 32'(3'b011));
    check("wrap_lane", 32'(spawn_lane), 7);

    // Halt with 40 frames left on the gap
    random = 5'b10110;
    do_reset();
    ticks(50);
    halt = 1'b1;
    ticks(1000);
    check("halt_nospawn", spawn_cnt, 0);
    check("halt_level", 32'(level), 0);
    halt = 1'b0;
    ticks(39);
    check("halt_resume_early", spawn_cnt, 0);
    ticks(1);
    halt = 1'b1;
    repeat (3) step();
    check("halt_pick_nospawn", spawn_cnt, 0);
    halt = 1'b0;
    step();
    check("halt_resume_spawn", 32'(spawn), 32'(3'b100));
    ticks(509);
    check("halt_lvl_before", 32'(level), 0);
    ticks(1);
    check("halt_lvl_after", 32'(level), 1);

    // Difficulty ramp with slots freed as soon as they launch
    do_reset();
    last_tick = 0;
    exp_gap = 90;
    for (int n = 1; n <= 6000; n++) begin
      frame_tick = 1'b1;
      slot_done = slot_active;
      step();
      frame_tick = 1'b0;
      slot_done = slot_active;
      step();
      if (spawn != 3'b000) begin
        check("ramp_gap", n - last_tick, exp_gap);
        last_tick = n;
        exp_gap = gap_model(lvl_model(n));
      end
      if (n == 600 || n == 4200 || n == 6000) check("ramp_level", 32'(level), lvl_model(n));
    end
    slot_done = 3'b000;

    // Reset while in PICK with slots occupied at max level
    got = 0;
    for (int k = 0; k < 100 && got == 0; k++) begin
      frame_tick = 1'b1; step();
      frame_tick = 0;    step();
      if (spawn != 3'b000) got = 1;
    end
    check("pre_rst_spawn_seen", got, 1);
    ticks(20);
    reset = 1'b1;
    halt = 1'b1;
    step();
    check("mid_rst_spawn", 32'(spawn), 0);
    check("mid_rst_active", 32'(slot_active), 0);
    check("mid_rst_lane", 32'(spawn_lane), 0);
    check("mid_rst_level", 32'(level), 0);
    reset = 1'b0;
    halt = 1'b0;
    spawn_cnt = 0;
    step(); step();
    ticks(89);
    check("mid_rst_nospawn", spawn_cnt, 0);
    ticks(1); step();
    check("mid_rst_gap90", 32'(spawn), 32'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
